// File: rtl/qtree_bool_stream_tx_if.sv
// qtree_bool_stream_tx_if: bus bundle of the QTree_Bool result serializer.
//   root_valid/root_ptr/root_ready : root pointer handshake, pointer = {addr, valid}
//   mem_rd_en/mem_rd_addr          : node memory read request
//   mem_rd_data                    : node word, one cycle after mem_rd_en
//   o_tdata/o_tvalid/o_tready/o_tlast : AXI-stream of node words
// The master modport is the serializer side; slave is the environment side.
interface qtree_bool_stream_tx_if #(
    parameter int PTR_W  = 16,
    parameter int NODE_W = 67
);
    logic              root_valid;
    logic [PTR_W:0]    root_ptr;
    logic              root_ready;
    logic              mem_rd_en;
    logic [PTR_W-1:0]  mem_rd_addr;
    logic [NODE_W-1:0] mem_rd_data;
    logic [NODE_W-1:0] o_tdata;
    logic              o_tvalid;
    logic              o_tready;
    logic              o_tlast;
    modport master (
        input  root_valid, root_ptr, mem_rd_data, o_tready,
        output root_ready, mem_rd_en, mem_rd_addr, o_tdata, o_tvalid, o_tlast
    );
    modport slave (
        output root_valid, root_ptr, mem_rd_data, o_tready,
        input  root_ready, mem_rd_en, mem_rd_addr, o_tdata, o_tvalid, o_tlast
    );
endinterface

// File: rtl/qtree_bool_stream_tx.sv
// qtree_bool_stream_tx: walks a QTree_Bool in node memory depth-first (pre-order, children 0..3)
// and streams one node word per beat, tlast on the final beat.
//   aclk, aresetn   : clock, asynchronous active-low reset
//   bus (master)    : root handshake, node memory read port, AXI-stream output
//   busy_o          : high whenever not idle
//   err_overflow_o  : sticky pending-stack overflow, cleared on the next root accept
module qtree_bool_stream_tx #(
    parameter int PTR_W       = 16,
    parameter int NODE_W      = 67,
    parameter int STACK_DEPTH = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    qtree_bool_stream_tx_if.master bus,
    output logic                  busy_o,
    output logic                  err_overflow_o
);
    localparam int PW   = PTR_W + 1;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int AW   = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, POP, WAIT, EMIT} state_t;

    state_t            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [PW-1:0]     stk_q [STACK_DEPTH];
    logic [NODE_W-1:0] tdata_q, tdata_d;
    logic              tlast_q, tlast_d;
    logic              err_q, err_d;
    logic              push_root, push_kids;
    logic [PW-1:0]     top;
    logic [4*PW-1:0]   kids;
    logic              is_node, ovf;

    assign top     = stk_q[AW'(sp_q - SP_W'(1))];
    // Child fields that fall beyond a narrow node word read as zero.
    assign kids    = (4*PW)'(bus.mem_rd_data >> 3);
    assign is_node = bus.mem_rd_data[1:0] == 2'b10;
    // Four pushes onto the already-popped stack must fit, otherwise the walk aborts.
    assign ovf     = int'(sp_q) + 4 > STACK_DEPTH;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            sp_q    <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
            err_q   <= err_d;
        end
    end

    // Child 3 goes deepest so child 0 ends on top of the stack.
    always_ff @(posedge aclk) begin
        if (push_root)
            stk_q[0] <= bus.root_ptr;
        else if (push_kids)
            for (int k = 0; k < 4; k++)
                stk_q[AW'(sp_q + SP_W'(k))] <= kids[(3-k)*PW +: PW];
    end

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        err_d     = err_q;
        push_root = 1'b0;
        push_kids = 1'b0;
        case (state_q)
            IDLE: if (bus.root_valid) begin
                push_root = 1'b1;
                sp_d      = SP_W'(1);
                err_d     = 1'b0;
                state_d   = POP;
            end
            POP: begin
                sp_d = sp_q - SP_W'(1);
                if (top[0]) state_d = WAIT;
                else begin
                    tdata_d = '0;
                    tlast_d = sp_q == SP_W'(1);
                    state_d = EMIT;
                end
            end
            WAIT: begin
                tdata_d = bus.mem_rd_data;
                state_d = EMIT;
                if (!is_node) tlast_d = sp_q == '0;
                else if (ovf) begin
                    err_d   = 1'b1;
                    sp_d    = '0;
                    tlast_d = 1'b1;
                end else begin
                    push_kids = 1'b1;
                    sp_d      = sp_q + SP_W'(4);
                    tlast_d   = 1'b0;
                end
            end
            EMIT: if (bus.o_tready) state_d = tlast_q ? IDLE : POP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.root_ready  = state_q == IDLE;
        bus.mem_rd_en   = state_q == POP && top[0];
        bus.mem_rd_addr = top[PW-1:1];
        bus.o_tvalid    = state_q == EMIT;
        bus.o_tdata     = tdata_q;
        bus.o_tlast     = tlast_q;
        busy_o          = state_q != IDLE;
        err_overflow_o  = err_q;
    end
endmodule

// File: tb/tb_qtree_bool_stream_tx.sv
// tb_qtree_bool_stream_tx: directed bench for the QTree_Bool stream serializer with a
// queue-based traversal model, per-cycle beat/read checker and literal pins.
module tb_qtree_bool_stream_tx;
    localparam int PTR_W  = 16;
    localparam int NODE_W = 67;
    localparam int DEPTH  = 4;
    localparam int PW     = PTR_W + 1;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic busy, err;

    qtree_bool_stream_tx_if #(.PTR_W(PTR_W), .NODE_W(NODE_W)) bus ();

    qtree_bool_stream_tx #(.PTR_W(PTR_W), .NODE_W(NODE_W), .STACK_DEPTH(DEPTH)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus),
        .busy_o(busy),
        .err_overflow_o(err)
    );

    always #5 aclk = ~aclk;

    logic [NODE_W-1:0] mem [64];
    always @(posedge aclk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr[5:0]];

    int n_cmp = 0;
    int n_bad = 0;
    logic [NODE_W:0] exp_q [$];
    logic [PTR_W-1:0] rd_q [$];
    bit exp_ovf;
    int nbeat, nread;
    logic [NODE_W:0] first_beat, prev_beat;
    bit stall_prev = 0;
    int tmode = 0;
    int tcnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ptr(input int a);
        return {PTR_W'(a), 1'b1};
    endfunction

    function automatic logic [NODE_W-1:0] val(input bit b);
        return NODE_W'({b, 2'b01});
    endfunction

    function automatic logic [NODE_W-1:0] mk_node(input logic [PW-1:0] c0, c1, c2, c3);
        logic [3+4*PW-1:0] x;
        x = '0;
        x[1:0] = 2'b10;
        x[3 +: PW] = c0;
        x[3+PW +: PW] = c1;
        x[3+2*PW +: PW] = c2;
        x[3+3*PW +: PW] = c3;
        return x[NODE_W-1:0];
    endfunction

    function automatic logic [PW-1:0] child(input logic [NODE_W-1:0] w, input int k);
        logic [3+4*PW-1:0] x;
        x = '0;
        x[NODE_W-1:0] = w;
        return x[3+k*PW +: PW];
    endfunction

    // Pre-order walk with a plain queue used as the pending stack.
    task automatic build(input logic [PW-1:0] root);
        logic [PW-1:0] st [$];
        logic [PW-1:0] p;
        logic [NODE_W-1:0] w;
        exp_ovf = 0;
        st.push_back(root);
        while (st.size() > 0) begin
            p = st.pop_back();
            w = p[0] ? mem[p[6:1]] : '0;
            if (p[0]) rd_q.push_back(p[PW-1:1]);
            if (w[1:0] == 2'b10) begin
                if (st.size() + 4 > DEPTH) begin
                    exp_ovf = 1;
                    st.delete();
                end else
                    for (int k = 3; k >= 0; k--) st.push_back(child(w, k));
            end
            exp_q.push_back({st.size() == 0, w});
        end
    endtask

    always @(posedge aclk) begin
        #1;
        tcnt = tcnt + 1;
        bus.o_tready = (tmode == 0) || (tcnt % 4 == 0) || (tcnt % 4 == 3);
    end

    always @(negedge aclk) begin
        if (!aresetn) stall_prev = 0;
        else begin
            if (bus.mem_rd_en) begin
                nread++;
                if (rd_q.size() > 0) chk("rd_addr", bus.mem_rd_addr, rd_q.pop_front());
                else chk("unexpected_read", bus.mem_rd_en, 0);
            end
            if (stall_prev) begin
                chk("stall_valid", bus.o_tvalid, 1);
                chk("stall_data", {bus.o_tlast, bus.o_tdata}, prev_beat);
            end
            if (bus.o_tvalid && bus.o_tready) begin
                nbeat++;
                if (nbeat == 1) first_beat = {bus.o_tlast, bus.o_tdata};
                if (exp_q.size() > 0) chk("beat", {bus.o_tlast, bus.o_tdata}, exp_q.pop_front());
                else chk("extra_beat", bus.o_tvalid, 0);
            end
            stall_prev = bus.o_tvalid && !bus.o_tready;
            prev_beat = {bus.o_tlast, bus.o_tdata};
        end
    end

    task automatic run(input logic [PW-1:0] root, input int mode, input int lat, input string name);
        int first;
        bit done;
        first = -1;
        done = 0;
        exp_q.delete();
        rd_q.delete();
        build(root);
        tmode = mode;
        nbeat = 0;
        nread = 0;
        @(posedge aclk);
        #1 bus.root_valid = 1;
        bus.root_ptr = root;
        @(negedge aclk);
        chk({name, "_root_ready"}, bus.root_ready, 1);
        @(posedge aclk);
        #1 bus.root_valid = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge aclk);
            if (c == 0) chk({name, "_err_clear"}, err, 0);
            if (first < 0 && bus.o_tvalid) first = c + 1;
            done = !busy;
        end
        chk({name, "_done"}, done, 1);
        chk({name, "_latency"}, first, lat);
        chk({name, "_beats_left"}, exp_q.size(), 0);
        chk({name, "_reads_left"}, rd_q.size(), 0);
        chk({name, "_err"}, err, exp_ovf);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit seen;
        bus.root_valid = 0;
        bus.root_ptr = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[5]  = val(1);
        mem[0]  = mk_node(ptr(1), ptr(2), ptr(3), ptr(4));
        mem[1]  = val(0);
        mem[2]  = val(1);
        mem[3]  = val(0);
        mem[4]  = val(1);
        mem[10] = mk_node(ptr(11), {PTR_W'(7), 1'b0}, '0, ptr(12));
        mem[11] = 67'h1_2345_6789_ABCD_EF03;
        mem[12] = mk_node(ptr(13), ptr(14), ptr(15), ptr(16));
        mem[13] = val(1);
        mem[14] = val(0);
        mem[15] = val(0);
        mem[16] = val(1);
        mem[20] = mk_node(ptr(21), ptr(1), ptr(1), ptr(1));
        mem[21] = mk_node(ptr(22), ptr(1), ptr(1), ptr(1));
        mem[22] = val(1);

        #2;
        chk("rst_tvalid", bus.o_tvalid, 0);
        chk("rst_tlast", bus.o_tlast, 0);
        chk("rst_tdata", bus.o_tdata, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_root_ready", bus.root_ready, 1);
        @(posedge aclk);
        @(posedge aclk);
        #3 aresetn = 1;

        run(ptr(5), 0, 3, "t1");
        chk("t1_beats", nbeat, 1);
        chk("t1_word", first_beat, {1'b1, 67'h5});
        chk("t1_reads", nread, 1);

        run(ptr(0), 0, 3, "t2");
        chk("t2_beats", nbeat, 5);
        chk("t2_reads", nread, 5);

        run(ptr(0), 1, 3, "t3");
        chk("t3_beats", nbeat, 5);

        run('0, 0, 2, "t4_null");
        chk("t4_beats", nbeat, 1);
        chk("t4_word", first_beat, {1'b1, 67'h0});
        chk("t4_reads", nread, 0);

        run(ptr(10), 0, 3, "t4_mixed");
        chk("t4m_beats", nbeat, 9);
        chk("t4m_reads", nread, 7);

        run(ptr(20), 0, 3, "t5");
        chk("t5_err", err, 1);
        chk("t5_beats", nbeat, 2);
        chk("t5_reads", nread, 2);

        run(ptr(5), 0, 3, "t5_next");

        exp_q.delete();
        rd_q.delete();
        build(ptr(0));
        tmode = 1;
        @(posedge aclk);
        #1 bus.root_valid = 1;
        bus.root_ptr = ptr(0);
        @(posedge aclk);
        #1 bus.root_valid = 0;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge aclk);
            seen = bus.o_tvalid && !bus.o_tready;
        end
        chk("t6_stalled", seen, 1);
        #2 aresetn = 0;
        stall_prev = 0;
        #1;
        chk("t6_tvalid", bus.o_tvalid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_err", err, 0);
        exp_q.delete();
        rd_q.delete();
        @(posedge aclk);
        @(posedge aclk);
        #3 aresetn = 1;
        @(negedge aclk);
        chk("t6_root_ready", bus.root_ready, 1);
        run(ptr(0), 0, 3, "t6_after");
        chk("t6_beats", nbeat, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
